// File: rtl/ctr_decrypt.sv
// AES-128 counter-mode decryptor with an iterative AES-128 encryption core
// (one round per cycle) producing the keystream for each ciphertext block.

module enc_aes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         done
);

    logic [127:0] st, rk, rk_nx, st_nx;
    logic [3:0]   rnd;
    logic         run;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        inv  = gmul(gmul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes+ShiftRows fused: output byte (row r, col c) comes from input col c+r
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic final_rnd);
        logic [127:0] t;
        int src;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            t[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
        end
        if (!final_rnd)
            for (int c = 0; c < 4; c++)
                t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
        return t ^ k;
    endfunction

    assign rk_nx      = next_key(rk, rcon(rnd));
    assign st_nx      = aes_round(st, rk_nx, rnd == 4'd10);
    assign ciphertext = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= '0;
            rk   <= '0;
            rnd  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (!enable) begin
            rnd  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (!run && !done) begin
            st  <= plaintext ^ key;
            rk  <= key;
            rnd <= 4'd1;
            run <= 1'b1;
        end else if (run) begin
            st  <= st_nx;
            rk  <= rk_nx;
            rnd <= rnd + 4'd1;
            if (rnd == 4'd10) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

module ctr_decrypt #(
    parameter int CTR_W = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din,
    input  logic         din_last,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT, S_OUT} state_t;

    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    state_t       state, state_nx;
    logic [127:0] key_q, ctr, ks, core_ct;
    logic         last_q, core_en, core_done;

    // Only the low CTR_W bits count; wrap is silent with no carry upward
    function automatic logic [127:0] ctr_inc(input logic [127:0] c);
        return (c & ~CTR_MASK) | ((c + 128'd1) & CTR_MASK);
    endfunction

    enc_aes u_core (
        .clk        (CLK),
        .rst_n      (RST_N),
        .enable     (core_en),
        .plaintext  (ctr),
        .key        (key_q),
        .ciphertext (core_ct),
        .done       (core_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        core_en    = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_nx = S_GEN;
            S_GEN: begin
                core_en = 1'b1;
                if (core_done) state_nx = S_WAIT;
            end
            S_WAIT: begin
                din_ready = 1'b1;
                if (din_valid) state_nx = S_OUT;
            end
            S_OUT: begin
                dout_valid = 1'b1;
                if (dout_ready) state_nx = last_q ? S_IDLE : S_GEN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_q  <= '0;
            ctr    <= '0;
            ks     <= '0;
            dout   <= '0;
            last_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                key_q <= key;
                ctr   <= iv;
            end
            if (state == S_GEN && core_done)
                ks <= core_ct;
            if (state == S_WAIT && din_valid) begin
                dout   <= din ^ ks;
                last_q <= din_last;
                ctr    <= ctr_inc(ctr);
            end
        end
    end

endmodule

// File: tb/tb_ctr_decrypt.sv
// Directed bench for ctr_decrypt: NIST CTR vectors, counter wrap, backpressure,
// mid-operation reset and a round trip against an independent AES model.

module tb_ctr_decrypt;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] KS_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         start;
    logic [127:0] key, iv, din, dout;
    logic         din_valid, din_ready, din_last;
    logic         dout_valid, dout_ready, busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb [256];

    ctr_decrypt #(.CTR_W(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .key        (key),
        .iv         (iv),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .din_last   (din_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box generated by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i + 4*(i%4)) % 16];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Key/iv are scrambled right after the pulse: later changes must not matter
    task automatic start_msg(input logic [127:0] k, input logic [127:0] v);
        @(negedge CLK);
        start = 1'b1; key = k; iv = v;
        @(negedge CLK);
        start = 1'b0; key = ~k; iv = ~v;
    endtask

    task automatic accept_din(input string tag, input logic [127:0] d, input logic l);
        int n;
        n = 0;
        while (!din_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_rdy"}, 128'(din_ready), 128'd1);
        din_valid = 1'b1; din = d; din_last = l;
        @(negedge CLK);
        din_valid = 1'b0; din = '0; din_last = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [127:0] d, input logic l,
                        input logic [127:0] exp);
        accept_din(tag, d, l);
        check({tag, "_vld"}, 128'(dout_valid), 128'd1);
        check(tag, dout, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout_valid"}, 128'(dout_valid), 128'd0);
        check({tag, "_din_ready"},  128'(din_ready),  128'd0);
        check({tag, "_busy"},       128'(busy),       128'd0);
        check({tag, "_dout"},       dout,             128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, v, c, pt, ks;
        build_sbox();
        RST_N = 1'b0; start = 1'b0; key = '0; iv = '0;
        din_valid = 1'b0; din = '0; din_last = 1'b0; dout_ready = 1'b1;
        repeat (3) @(negedge CLK);
        check_zero_outputs("rst");
        RST_N = 1'b1;

        // NIST blocks 1 and 2, then back to idle
        start_msg(K1, IV1);
        check("gen_busy", 128'(busy), 128'd1);
        xfer("nist_b1", C1, 1'b0, P1);
        xfer("nist_b2", C2, 1'b1, P2);
        @(negedge CLK);
        check("end_busy", 128'(busy), 128'd0);
        check("end_vld", 128'(dout_valid), 128'd0);

        // counter wrap: second keystream is AES(0, 0)
        v = {96'h0, 32'hffffffff};
        ks = aes_model(128'h0, v);
        pt = rnd128();
        start_msg(128'h0, v);
        xfer("wrap_b1", pt ^ ks, 1'b0, pt);
        xfer("wrap_b2", KS_ZERO, 1'b1, 128'h0);
        @(negedge CLK);

        // backpressure, with a stray start during OUT that must be ignored
        start_msg(K1, IV1);
        accept_din("bp", C1, 1'b0);
        dout_ready = 1'b0;
        start = 1'b1; key = rnd128(); iv = rnd128();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            start = 1'b0;
            check("bp_vld", 128'(dout_valid), 128'd1);
            check("bp_dout", dout, P1);
            check("bp_rdy", 128'(din_ready), 128'd0);
        end
        dout_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_vld", 128'(dout_valid), 128'd0);
        check("bp_release_busy", 128'(busy), 128'd1);
        xfer("bp_b2", C2, 1'b1, P2);
        @(negedge CLK);

        // reset during GEN, then during OUT, then a clean message
        start_msg(K1, IV1);
        @(negedge CLK);
        check("rg_busy", 128'(busy), 128'd1);
        #1 RST_N = 1'b0;
        #1 check_zero_outputs("rst_gen");
        @(negedge CLK);
        RST_N = 1'b1;
        start_msg(K1, IV1);
        xfer("ro_b1", C1, 1'b0, P1);
        #1 RST_N = 1'b0;
        #1 check_zero_outputs("rst_out");
        @(negedge CLK);
        RST_N = 1'b1;
        start_msg(K1, IV1);
        xfer("post_rst", C1, 1'b1, P1);
        @(negedge CLK);
        check("post_rst_busy", 128'(busy), 128'd0);

        // round trip against the encrypt-side model
        k = rnd128();
        v = rnd128();
        c = v;
        start_msg(k, v);
        for (int i = 0; i < 8; i++) begin
            pt = rnd128();
            xfer("rt", pt ^ aes_model(k, c), (i == 7), pt);
            c = {c[127:32], c[31:0] + 32'd1};
        end
        @(negedge CLK);
        check("rt_busy", 128'(busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
